// File: rtl/piso_serializer.sv
// Purpose: parallel-in/serial-out shifter, WIDTH-bit word out one bit per accepted beat.
// Latency: first bit valid the cycle after the word is accepted; frames chain with no bubble.
// Backpressure: out_ready=0 freezes the current bit/last flag; in_ready only on idle or last beat.
module piso_serializer #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             load, beat;

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output decode, handshakes and next-state/datapath selection.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;

    out_valid = (state == SHIFT);
    busy      = out_valid;
    out       = out_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
    out_last  = out_valid && (cnt == LAST_CNT);
    beat      = out_valid && out_ready;
    // A new word can enter on the very beat that retires the old one.
    in_ready  = (state == IDLE) || (beat && out_last);
    load      = in_valid && in_ready;

    case (state)
      IDLE: begin
        if (load) begin
          shreg_nxt = in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (out_last) begin
            cnt_nxt = '0;
            if (load) begin
              shreg_nxt = in_data;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            // Move the next bit toward the output end, backfilling with the idle level.
            shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], IDLE_BIT}
                                  : {IDLE_BIT, shreg[WIDTH-1:1]};
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
